// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, an iterative
// shift-add multiplier and the EX/MEM pipeline register feeding the MEM stage.
module ex_stage #(
    parameter int PC_WIDTH      = 15,
    parameter int DATA_WIDTH    = 16,
    parameter int REGADDR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic [1:0]               ex_alu_op,
    input  logic                     ex_alu_src,
    input  logic                     ex_branch,
    input  logic [2:0]               ex_funct,
    input  logic [PC_WIDTH-1:0]      ex_pc,
    input  logic [DATA_WIDTH-1:0]    ex_reg_data1,
    input  logic [DATA_WIDTH-1:0]    ex_reg_data2,
    input  logic [DATA_WIDTH-1:0]    ex_imm_ext,
    input  logic [REGADDR_WIDTH-1:0] ex_rs,
    input  logic [REGADDR_WIDTH-1:0] ex_rt,
    input  logic [REGADDR_WIDTH-1:0] ex_rd,
    input  logic                     wb_reg_write,
    input  logic [REGADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     mem_reg_write,
    output logic                     mem_mem_read,
    output logic                     mem_mem_write,
    output logic [DATA_WIDTH-1:0]    mem_alu_result,
    output logic [DATA_WIDTH-1:0]    mem_store_data,
    output logic [REGADDR_WIDTH-1:0] mem_rd,
    output logic                     branch_taken,
    output logic [PC_WIDTH-1:0]      branch_target,
    output logic                     stall
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    mul_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]    mcand_q;
    logic [DATA_WIDTH-1:0]    mplier_q;
    logic [DATA_WIDTH-1:0]    acc_q;
    logic [CNT_WIDTH-1:0]     cnt_q;

    logic [DATA_WIDTH-1:0]    op_a;
    logic [DATA_WIDTH-1:0]    op_b_reg;
    logic [DATA_WIDTH-1:0]    op_b;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    ex_result;
    logic [REGADDR_WIDTH-1:0] dest;
    logic                     is_mul;
    logic                     stall_raw;

    // A load sitting in EX/MEM has no data yet, so it is never a forwarding source.
    always_comb begin
        op_a = ex_reg_data1;
        if (mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == ex_rs))
            op_a = mem_alu_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))
            op_a = wb_data;
    end

    always_comb begin
        op_b_reg = ex_reg_data2;
        if (mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == ex_rt))
            op_b_reg = mem_alu_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt))
            op_b_reg = wb_data;
    end

    assign op_b   = ex_alu_src ? ex_imm_ext : op_b_reg;
    assign is_mul = (ex_alu_op == 2'b10) && (ex_funct == 3'b111);
    assign dest   = (ex_alu_op == 2'b10) ? ex_rd : ex_rt;

    // The mul slot yields zero here; its product comes from the accumulator.
    always_comb begin
        alu_result = '0;
        case (ex_alu_op)
            2'b00: alu_result = op_a + op_b;
            2'b01: alu_result = op_a - op_b;
            2'b11: alu_result = op_b;
            default: begin
                case (ex_funct)
                    3'b000:  alu_result = op_a + op_b;
                    3'b001:  alu_result = op_a - op_b;
                    3'b010:  alu_result = op_a & op_b;
                    3'b011:  alu_result = op_a | op_b;
                    3'b100:  alu_result = op_a ^ op_b;
                    3'b101:  alu_result = op_a << op_b[3:0];
                    3'b110:  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    default: alu_result = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    state_d   = RUN;
                    stall_raw = 1'b1;
                end
            end
            RUN: begin
                stall_raw = 1'b1;
                if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset drops the FSM to IDLE asynchronously, but a mul held at the ID/EX
    // inputs would still look like a new start, so stall is masked explicitly.
    assign stall = stall_raw && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    if (mplier_q[0])
                        acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ex_result = (state_q == DONE) ? acc_q : alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
        end else if (stall) begin
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
        end else begin
            mem_reg_write  <= ex_reg_write;
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
            mem_alu_result <= ex_result;
            mem_store_data <= op_b_reg;
            mem_rd         <= dest;
        end
    end

    assign branch_taken  = ex_branch && (op_a == op_b_reg) && !stall && !reset;
    assign branch_target = ex_pc + ex_imm_ext[PC_WIDTH-1:0];

endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: the driver predicts each EX/MEM
// result from a behavioural model and a negedge monitor pops and compares.
module tb_ex_stage;

    localparam int PW = 15;
    localparam int DW = 16;
    localparam int RW = 4;
    localparam int EW = 3 + DW + DW + RW;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch;
    logic [1:0]    ex_alu_op;
    logic [2:0]    ex_funct;
    logic [PW-1:0] ex_pc;
    logic [DW-1:0] ex_reg_data1, ex_reg_data2, ex_imm_ext;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
    logic          wb_reg_write;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          mem_reg_write, mem_mem_read, mem_mem_write;
    logic [DW-1:0] mem_alu_result, mem_store_data;
    logic [RW-1:0] mem_rd;
    logic          branch_taken;
    logic [PW-1:0] branch_target;
    logic          stall;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_funct(ex_funct), .ex_pc(ex_pc),
        .ex_reg_data1(ex_reg_data1), .ex_reg_data2(ex_reg_data2), .ex_imm_ext(ex_imm_ext),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall)
    );

    typedef struct {
        logic          rw, mr, mw, src, br;
        logic [1:0]    op;
        logic [2:0]    fn;
        logic [PW-1:0] pc;
        logic [DW-1:0] d1, d2, imm;
        logic [RW-1:0] rs, rt, rd;
    } instr_t;

    int            n_vec = 0;
    int            n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;

    // Reference view of the EX/MEM register, used for forwarding prediction.
    logic          m_rw, m_mr;
    logic [DW-1:0] m_res;
    logic [RW-1:0] m_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src, input logic [DW-1:0] idv);
        if (m_rw && !m_mr && m_rd != 0 && m_rd == src) return m_res;
        if (wb_reg_write && wb_rd != 0 && wb_rd == src) return wb_data;
        return idv;
    endfunction

    function automatic logic [DW-1:0] alu_ref(input logic [1:0] op, input logic [2:0] fn,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        if (op == 2'd0) r = a + b;
        else if (op == 2'd1) r = a - b;
        else if (op == 2'd3) r = b;
        else begin
            case (fn)
                3'd0: r = a + b;
                3'd1: r = a - b;
                3'd2: r = a & b;
                3'd3: r = a | b;
                3'd4: r = a ^ b;
                3'd5: r = a << b[3:0];
                3'd6: r = ($signed(a) < $signed(b)) ? 1 : 0;
                default: r = a * b;
            endcase
        end
        return r;
    endfunction

    task automatic model_clear();
        m_rw = 1'b0; m_mr = 1'b0; m_res = '0; m_rd = '0;
    endtask

    task automatic drive(input instr_t i);
        ex_reg_write = i.rw; ex_mem_read = i.mr; ex_mem_write = i.mw;
        ex_alu_op = i.op; ex_alu_src = i.src; ex_branch = i.br; ex_funct = i.fn;
        ex_pc = i.pc; ex_reg_data1 = i.d1; ex_reg_data2 = i.d2; ex_imm_ext = i.imm;
        ex_rs = i.rs; ex_rt = i.rt; ex_rd = i.rd;
    endtask

    function automatic instr_t nop();
        instr_t i;
        i.rw = 0; i.mr = 0; i.mw = 0; i.src = 0; i.br = 0; i.op = 0; i.fn = 0;
        i.pc = 0; i.d1 = 0; i.d2 = 0; i.imm = 0; i.rs = 0; i.rt = 0; i.rd = 0;
        return i;
    endfunction

    task automatic set_wb(input logic w, input logic [RW-1:0] r, input logic [DW-1:0] d);
        wb_reg_write = w; wb_rd = r; wb_data = d;
    endtask

    task automatic record(input instr_t i, input logic [DW-1:0] res,
                          input logic [DW-1:0] sd, input logic [RW-1:0] dest);
        if (i.rw || i.mr || i.mw) exp_q.push_back({i.rw, i.mr, i.mw, res, sd, dest});
    endtask

    // Issue one instruction into EX and follow it until it is captured by EX/MEM.
    task automatic issue(input instr_t i, input logic wbw, input logic [RW-1:0] wbr,
                         input logic [DW-1:0] wbd);
        logic [DW-1:0] a, breg, b, res;
        logic [RW-1:0] dest;
        int            stalls;
        @(negedge clk);
        drive(i);
        set_wb(wbw, wbr, wbd);
        #1;
        a    = fwd(i.rs, i.d1);
        breg = fwd(i.rt, i.d2);
        b    = i.src ? i.imm : breg;
        dest = (i.op == 2'd2) ? i.rd : i.rt;
        res  = alu_ref(i.op, i.fn, a, b);
        chk("branch_target", branch_target, PW'(i.pc + i.imm[PW-1:0]));
        if (!(i.op == 2'd2 && i.fn == 3'd7)) begin
            chk("stall_idle", stall, 0);
            chk("branch_taken", branch_taken, i.br && (a == breg));
            record(i, res, breg, dest);
            @(posedge clk);
            m_rw = i.rw; m_mr = i.mr; m_res = res; m_rd = dest;
        end else begin
            stalls = 0;
            while (stall === 1'b1 && stalls < 40) begin
                stalls++;
                if (stalls > 1) begin
                    chk("bubble_ctrl", {mem_reg_write, mem_mem_read, mem_mem_write}, 0);
                    chk("bubble_data", {mem_alu_result, mem_store_data, mem_rd}, 0);
                end
                chk("branch_in_stall", branch_taken, 0);
                @(posedge clk);
                model_clear();
                @(negedge clk);
                set_wb(1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)), DW'($urandom));
                #1;
            end
            chk("mul_stall_cycles", stalls, 17);
            record(i, res, fwd(i.rt, i.d2), dest);
            @(posedge clk);
            m_rw = i.rw; m_mr = i.mr; m_res = res; m_rd = dest;
        end
    endtask

    function automatic instr_t mk(input logic [1:0] op, input logic [2:0] fn, input logic src,
                                  input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                  input logic [DW-1:0] imm, input logic [RW-1:0] rs,
                                  input logic [RW-1:0] rt, input logic [RW-1:0] rd);
        instr_t i;
        i = nop();
        i.rw = 1; i.op = op; i.fn = fn; i.src = src;
        i.d1 = d1; i.d2 = d2; i.imm = imm; i.rs = rs; i.rt = rt; i.rd = rd;
        i.pc = PW'($urandom);
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.op  = 2'($urandom_range(0, 3));
        i.fn  = 3'($urandom_range(0, 7));
        if (i.op == 2'd2 && i.fn == 3'd7 && $urandom_range(0, 3) != 0)
            i.fn = 3'($urandom_range(0, 6));
        i.rw  = ($urandom_range(0, 3) != 0);
        i.mr  = ($urandom_range(0, 4) == 0);
        i.mw  = ($urandom_range(0, 4) == 0);
        i.src = 1'($urandom_range(0, 1));
        i.br  = ($urandom_range(0, 3) == 0) && !(i.op == 2'd2 && i.fn == 3'd7);
        i.pc  = PW'($urandom);
        i.d1  = DW'($urandom);
        i.d2  = DW'($urandom);
        i.imm = DW'($urandom);
        i.rs  = RW'($urandom_range(0, 3));
        i.rt  = RW'($urandom_range(0, 3));
        i.rd  = RW'($urandom_range(0, 3));
        if (i.br && $urandom_range(0, 1) == 1) begin
            i.rt = i.rs;
            i.d2 = i.d1;
        end
        return i;
    endfunction

    task automatic chk_outputs_zero(input string name);
        chk(name, {mem_reg_write, mem_mem_read, mem_mem_write, mem_alu_result, mem_store_data, mem_rd}, 0);
        chk("reset_stall", stall, 0);
        chk("reset_branch", branch_taken, 0);
    endtask

    // Scoreboard monitor: any EX/MEM entry with a live control bit must match the queue head.
    always @(negedge clk) begin
        if (reset === 1'b0 && (mem_reg_write || mem_mem_read || mem_mem_write)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("ex_mem", {mem_reg_write, mem_mem_read, mem_mem_write,
                               mem_alu_result, mem_store_data, mem_rd}, exp_e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        instr_t i;
        model_clear();
        set_wb(0, 0, 0);
        // Reset with a mul and an equal-operand branch presented: nothing may fire.
        i = mk(2'd2, 3'd7, 0, 16'h0123, 16'h0123, 0, 8, 9, 4);
        i.br = 1;
        drive(i);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset_init");
        drive(nop());
        @(negedge clk);
        reset = 1'b0;

        // Basic add with immediate.
        issue(mk(2'd0, 0, 1, 16'h0003, 16'h0000, 16'h0004, 8, 5, 0), 0, 0, 0);
        // Reset while EX/MEM holds a live result.
        #1;
        reset = 1'b1;
        #1;
        chk_outputs_zero("reset_live");
        exp_q.delete();
        model_clear();
        drive(nop());
        @(negedge clk);
        reset = 1'b0;

        // Forwarding priority: EX/MEM over WB, load not forwarded, r0 never forwarded.
        issue(mk(2'd3, 0, 1, 0, 0, 16'h00AA, 8, 2, 0), 0, 0, 0);
        issue(mk(2'd2, 3'd0, 1, 16'h0011, 0, 16'h0001, 2, 9, 3), 1, 2, 16'h0055);
        i = mk(2'd0, 0, 1, 16'h0100, 0, 0, 8, 2, 0);
        i.mr = 1;
        issue(i, 0, 0, 0);
        issue(mk(2'd2, 3'd0, 1, 16'h0011, 0, 16'h0001, 2, 9, 3), 1, 2, 16'h0055);
        issue(mk(2'd3, 0, 1, 0, 0, 16'h0099, 8, 0, 0), 0, 0, 0);
        issue(mk(2'd2, 3'd0, 1, 16'h0010, 0, 16'h0001, 0, 9, 3), 1, 0, 16'h0055);

        // Branch taken / not taken.
        i = nop();
        i.br = 1; i.op = 2'd1; i.d1 = 16'h0123; i.d2 = 16'h0123;
        i.pc = 15'h0010; i.imm = 16'h0004; i.rs = 8; i.rt = 9;
        issue(i, 0, 0, 0);
        i.d2 = 16'h0124;
        issue(i, 0, 0, 0);

        // Multiplies.
        issue(mk(2'd2, 3'd7, 0, 16'h0007, 16'h0009, 0, 8, 9, 4), 0, 0, 0);
        issue(mk(2'd2, 3'd7, 0, 16'h1234, 16'h0010, 0, 8, 9, 5), 0, 0, 0);

        // Reset in the fifth RUN cycle aborts the multiply.
        @(negedge clk);
        drive(mk(2'd2, 3'd7, 0, 16'h00FF, 16'h0003, 0, 8, 9, 6));
        set_wb(0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        chk("stall_in_run", stall, 1);
        reset = 1'b1;
        #1;
        chk_outputs_zero("reset_mid_mul");
        exp_q.delete();
        model_clear();
        drive(nop());
        @(negedge clk);
        reset = 1'b0;
        issue(mk(2'd2, 3'd7, 0, 16'h00FF, 16'h0003, 0, 8, 9, 6), 0, 0, 0);

        // slt, sll, xor corner values.
        issue(mk(2'd2, 3'd6, 0, 16'hFFFF, 16'h0001, 0, 8, 9, 7), 0, 0, 0);
        issue(mk(2'd2, 3'd5, 0, 16'h0001, 16'h0013, 0, 8, 9, 7), 0, 0, 0);
        issue(mk(2'd2, 3'd4, 0, 16'hF0F0, 16'hFF00, 0, 8, 9, 7), 0, 0, 0);

        // Randomized traffic with dense register reuse.
        for (int n = 0; n < 300; n++)
            issue(rand_instr(), 1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)), DW'($urandom));

        @(negedge clk);
        drive(nop());
        set_wb(0, 0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes the ID/EX register outputs and applies EX/MEM and WB forwarding to the operands.
- Performs ALU ops and branch resolution, and runs an iterative multi-cycle multiply.
- Contains the EX/MEM pipeline register that drives the MEM stage.
- Raises stall while a multiply is in progress so upstream stages freeze.

Parameters:
PC_WIDTH, 15, instruction address width (word addressed)
DATA_WIDTH, 16, datapath/register width
REGADDR_WIDTH, 4, register index width; register 0 is hardwired zero

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
ex_reg_write  input  1  ID/EX control: instruction writes a register
ex_mem_read  input  1  ID/EX control: load
ex_mem_write  input  1  ID/EX control: store
ex_alu_op  input  2  00 add, 01 sub (branch compare), 10 R-type via ex_funct, 11 pass imm
ex_alu_src  input  1  1 = operand B is ex_imm_ext
ex_branch  input  1  branch-if-equal
ex_funct  input  3  R-type function select
ex_pc  input  PC_WIDTH  PC of instruction in EX
ex_reg_data1  input  DATA_WIDTH  rs value read in ID
ex_reg_data2  input  DATA_WIDTH  rt value read in ID
ex_imm_ext  input  DATA_WIDTH  sign-extended immediate
ex_rs, ex_rt, ex_rd  input  REGADDR_WIDTH  register indices
wb_reg_write  input  1  WB stage write enable
wb_rd  input  REGADDR_WIDTH  WB destination
wb_data  input  DATA_WIDTH  WB write data
mem_reg_write, mem_mem_read, mem_mem_write  output  1 each  EX/MEM control
mem_alu_result  output  DATA_WIDTH  EX/MEM result / address
mem_store_data  output  DATA_WIDTH  forwarded rt value for stores
mem_rd  output  REGADDR_WIDTH  EX/MEM destination
branch_taken  output  1  combinational, redirect fetch + flush IF/ID, ID/EX
branch_target  output  PC_WIDTH  combinational, ex_pc + ex_imm_ext
stall  output  1  combinational; IF/ID and ID/EX hold while high

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All EX/MEM outputs go to 0 and the FSM goes to IDLE. stall=0 and branch_taken=0 while reset is asserted. Reset mid-multiply aborts it; no result is produced.
- Forwarding, per operand (rs→A, rt→B_reg):
  - EX/MEM source is used if mem_reg_write && !mem_mem_read && mem_rd!=0 && mem_rd==src.
  - Otherwise WB source is used if wb_reg_write && wb_rd!=0 && wb_rd==src.
  - Otherwise the ID/EX value is used.
  - EX/MEM has priority over WB.
  - Load-use is not forwarded from EX/MEM; the hazard unit stalls that case upstream.
- Operand B = ex_alu_src ? ex_imm_ext : B_reg. mem_store_data = B_reg.
- ALU ops, all results modulo 2^DATA_WIDTH:
  - op 00: A+B
  - op 01: A−B
  - op 11: B
  - op 10, by funct: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll by B[3:0], 110 signed slt (result 1/0), 111 mul (low DATA_WIDTH bits).
- Destination: dest = (ex_alu_op==10) ? ex_rd : ex_rt.
- Branch: branch_taken = ex_branch && (A==B_reg) && !stall. branch_target = ex_pc + ex_imm_ext[PC_WIDTH-1:0], truncated.
- Multiply FSM:
  - States: IDLE, RUN, DONE.
  - IDLE: on an R-type mul (op 10, funct 111), latch A and B, clear accumulator and counter, go to RUN; stall=1 this cycle.
  - RUN: each cycle, if the multiplier LSB=1 add the multiplicand to the accumulator; shift multiplicand left and multiplier right; counter++. After DATA_WIDTH iterations go to DONE; stall=1 in every RUN cycle.
  - DONE: stall=0; EX/MEM captures the accumulator; next state is IDLE unconditionally, with no restart on the same instruction.
  - Total stall = DATA_WIDTH+1 cycles (17 at default).
  - Operands are latched, so wb_* changes during RUN do not affect the product.
- EX/MEM register:
  - Every rising edge with stall=0: capture controls, result, store data, dest.
  - With stall=1: load a bubble (all controls 0, data 0).
- A non-mul instruction has 1-cycle latency from ID/EX to EX/MEM.

Test Plan:
1. A=ex_reg_data1=3, B via alu_src imm=4, op 00 → next edge mem_alu_result=0x0007, mem_rd=ex_rt, mem_reg_write=1.
2. rs=2; EX/MEM holds rd=2, result 0x00AA; WB has rd=2, data 0x0055; R-type add with B=1 → 0x00AB (EX/MEM wins). Repeat with mem_mem_read=1 → 0x0056. Repeat with rd=0 on both → ID/EX value used.
3. ex_branch=1, A=B=0x0123, pc=0x0010, imm=0x0004 → branch_taken=1, branch_target=0x0014 same cycle. A≠B → branch_taken=0.
4. mul 0x0007×0x0009 → stall high exactly 17 cycles, bubbles in EX/MEM during stall, then mem_alu_result=0x003F with mem_reg_write=1. mul 0x1234×0x0010 → 0x2340.
5. Assert reset in the 5th RUN cycle → all outputs 0 immediately, stall=0; the next mul restarts cleanly and yields the correct product.
6. funct 110 A=0xFFFF, B=0x0001 → 0x0001. funct 101 A=0x0001, B=0x0013 → 0x0008. funct 100 A=0xF0F0, B=0xFF00 → 0x0FF0.
